// File: rtl/ir_pipe_pkg.sv
// rtl/ir_pipe_pkg.sv - shared constants and types for the elastic IR pipeline
package ir_pipe_pkg;
    localparam logic [31:0] NOP_WORD_RV32 = 32'h0000_0013;
    typedef logic [31:0] instr_t;
endpackage

// File: rtl/ir_pipe_chain_if.sv
// rtl/ir_pipe_chain_if.sv - upstream/downstream handshake bundle of the IR pipeline
interface ir_pipe_chain_if #(
    parameter int WIDTH = 32
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_data;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_data;

    modport master (
        output in_valid, in_data, out_ready,
        input  in_ready, out_valid, out_data
    );

    modport slave (
        input  in_valid, in_data, out_ready,
        output in_ready, out_valid, out_data
    );
endinterface

// File: rtl/ir_pipe_stage.sv
// rtl/ir_pipe_stage.sv - one valid+data register with load and flush
module ir_pipe_stage
    import ir_pipe_pkg::*;
#(
    parameter int               WIDTH    = 32,
    parameter logic [WIDTH-1:0] NOP_WORD = WIDTH'(NOP_WORD_RV32)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush_i,
    input  logic             load_i,
    input  logic             valid_i,
    input  logic [WIDTH-1:0] data_i,
    output logic             valid_o,
    output logic [WIDTH-1:0] data_o
);
    logic             valid_q;
    logic [WIDTH-1:0] data_q;

    // Flush beats load; data only moves with a valid word so bubbles keep the old value
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid_q <= 1'b0;
            data_q  <= NOP_WORD;
        end else if (flush_i) begin
            valid_q <= 1'b0;
            data_q  <= NOP_WORD;
        end else if (load_i) begin
            valid_q <= valid_i;
            if (valid_i) begin
                data_q <= data_i;
            end
        end
    end

    assign valid_o = valid_q;
    assign data_o  = data_q;
endmodule

// File: rtl/ir_pipe_chain.sv
// rtl/ir_pipe_chain.sv - elastic STAGES-deep IR pipeline with flush; optional skid entry via IR_PIPE_SKID_EN
module ir_pipe_chain
    import ir_pipe_pkg::*;
#(
    parameter int               WIDTH    = 32,
    parameter int               STAGES   = 2,
    parameter logic [WIDTH-1:0] NOP_WORD = WIDTH'(NOP_WORD_RV32),
    localparam int              OCC_W    = $clog2(STAGES + 2)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    ir_pipe_chain_if.slave   bus,
    output logic [OCC_W-1:0] occupancy
);
    logic [STAGES:0]   adv;
    logic [STAGES-1:0] v;
    logic [WIDTH-1:0]  d [STAGES];
    logic              src_v;
    logic [WIDTH-1:0]  src_d;
    logic              skid_cnt;

    // Advance chain: a stage moves when it is empty or the stage after it moves
    always_comb begin
        logic chain;
        chain       = bus.out_ready;
        adv         = '0;
        adv[STAGES] = chain;
        for (int i = STAGES - 1; i >= 0; i--) begin
            chain  = !v[i] || chain;
            adv[i] = chain;
        end
    end

    for (genvar i = 0; i < STAGES; i++) begin : g_stage
        logic             vin;
        logic [WIDTH-1:0] din;
        if (i == 0) begin : g_first
            assign vin = src_v;
            assign din = src_d;
        end else begin : g_next
            assign vin = v[i-1];
            assign din = d[i-1];
        end
        ir_pipe_stage #(
            .WIDTH    (WIDTH),
            .NOP_WORD (NOP_WORD)
        ) u_stage (
            .clk     (clk),
            .rst     (rst),
            .flush_i (flush),
            .load_i  (adv[i]),
            .valid_i (vin),
            .data_i  (din),
            .valid_o (v[i]),
            .data_o  (d[i])
        );
    end

    assign bus.out_valid = v[STAGES-1];
    assign bus.out_data  = d[STAGES-1];

`ifdef IR_PIPE_SKID_EN
    logic             skid_v_q, skid_v_d;
    logic [WIDTH-1:0] skid_d_q, skid_d_d;
    logic             in_ready_q;
    logic             accept;

    // in_ready is registered, so a flush cannot gate it; a word taken during flush is killed
    assign accept      = bus.in_valid && in_ready_q;
    assign src_v       = skid_v_q || accept;
    assign src_d       = skid_v_q ? skid_d_q : bus.in_data;
    assign bus.in_ready = in_ready_q;
    assign skid_cnt    = skid_v_q;

    // Skid next state: park a word stage 0 cannot take, drain it first when stage 0 moves
    always_comb begin
        skid_v_d = skid_v_q;
        skid_d_d = skid_d_q;
        if (flush) begin
            skid_v_d = 1'b0;
        end else if (skid_v_q) begin
            if (adv[0]) begin
                skid_v_d = 1'b0;
            end
        end else if (accept && !adv[0]) begin
            skid_v_d = 1'b1;
            skid_d_d = bus.in_data;
        end
    end

    // Skid register and the flopped ready that mirrors its emptiness
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            skid_v_q   <= 1'b0;
            skid_d_q   <= NOP_WORD;
            in_ready_q <= 1'b0;
        end else begin
            skid_v_q   <= skid_v_d;
            skid_d_q   <= skid_d_d;
            in_ready_q <= !skid_v_d;
        end
    end
`else
    assign src_v        = bus.in_valid;
    assign src_d        = bus.in_data;
    assign bus.in_ready = adv[0] && !flush && !rst;
    assign skid_cnt     = 1'b0;
`endif

    // Occupancy is the count of valid words held, skid entry included
    always_comb begin
        occupancy = OCC_W'(skid_cnt);
        for (int i = 0; i < STAGES; i++) begin
            occupancy = occupancy + OCC_W'(v[i]);
        end
    end
endmodule

// File: tb/tb_ir_pipe_chain.sv
// tb/tb_ir_pipe_chain.sv - self-checking bench for ir_pipe_chain (STAGES=2 and STAGES=3 instances)
module tb_ir_pipe_chain;
    import ir_pipe_pkg::*;

    localparam int W = 32;
`ifdef IR_PIPE_SKID_EN
    localparam int CAP3 = 4;
`else
    localparam int CAP3 = 3;
`endif
    localparam instr_t NOP = 32'h0000_0013;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       flush2 = 1'b0;
    logic       flush3 = 1'b0;
    logic [1:0] occ2;
    logic [2:0] occ3;
    int         checks = 0;
    int         errors = 0;

    ir_pipe_chain_if #(.WIDTH(W)) b2 ();
    ir_pipe_chain_if #(.WIDTH(W)) b3 ();

    ir_pipe_chain #(.WIDTH(W), .STAGES(2)) dut2 (
        .clk(clk), .rst(rst), .flush(flush2), .bus(b2), .occupancy(occ2)
    );
    ir_pipe_chain #(.WIDTH(W), .STAGES(3)) dut3 (
        .clk(clk), .rst(rst), .flush(flush3), .bus(b3), .occupancy(occ3)
    );

    always #5 clk = ~clk;

`ifdef IR_PIPE_SKID_EN
    time t_edge = 0;
    always @(posedge clk) t_edge = $time;
    always @(b3.in_ready or b2.in_ready) begin
        if (!rst) begin
            checks++;
            assert ($time == t_edge) else begin
                errors++;
                $display("FAIL in_ready_flop: in_ready changed at %0t, last clock edge %0t", $time, t_edge);
            end
        end
    end
`endif

    task automatic next();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        repeat (2) @(posedge clk);
        #1;
        checks++; if (b3.out_valid !== 1'b0) begin errors++; $display("FAIL rst_out_valid: got %b want 0", b3.out_valid); end
        checks++; if (occ3 !== 3'd0) begin errors++; $display("FAIL rst_occ: got %0d want 0", occ3); end
        checks++; if (b3.in_ready !== 1'b0) begin errors++; $display("FAIL rst_in_ready: got %b want 0", b3.in_ready); end
        checks++; if (b2.out_data !== NOP) begin errors++; $display("FAIL rst_out_data2: got %h want %h", b2.out_data, NOP); end
        rst = 1'b0;
        next();
        b3.out_ready = 1'b0;
        b3.in_valid = 1'b1; b3.in_data = 32'h11; next();
        b3.in_data = 32'h22; next();
        b3.in_valid = 1'b0;
        repeat (3) next();
        checks++; if (occ3 !== 3'd2) begin errors++; $display("FAIL pre_rst_occ: got %0d want 2", occ3); end
        checks++; if (b3.out_valid !== 1'b1 || b3.out_data !== 32'h11) begin errors++; $display("FAIL pre_rst_out: got %b/%h want 1/00000011", b3.out_valid, b3.out_data); end
        #2 rst = 1'b1;
        #1;
        checks++; if (b3.out_valid !== 1'b0) begin errors++; $display("FAIL async_out_valid: got %b want 0", b3.out_valid); end
        checks++; if (b3.out_data !== NOP) begin errors++; $display("FAIL async_out_data: got %h want %h", b3.out_data, NOP); end
        checks++; if (occ3 !== 3'd0) begin errors++; $display("FAIL async_occ: got %0d want 0", occ3); end
        checks++; if (b3.in_ready !== 1'b0) begin errors++; $display("FAIL async_in_ready: got %b want 0", b3.in_ready); end
        #1 rst = 1'b0;
        next();
    endtask

    task automatic test_stream();
        logic   ev;
        instr_t ed;
        b2.out_ready = 1'b1;
        for (int c = 0; c < 6; c++) begin
            b2.in_valid = (c < 3);
            b2.in_data  = 32'hA1 + 32'(c);
            @(negedge clk);
            ev = (c >= 2 && c <= 4);
            ed = 32'hA1 + 32'(c) - 32'd2;
            if (c < 3) begin
                checks++; if (b2.in_ready !== 1'b1) begin errors++; $display("FAIL stream_in_ready c=%0d: got %b want 1", c, b2.in_ready); end
            end
            checks++; if (b2.out_valid !== ev) begin errors++; $display("FAIL stream_out_valid c=%0d: got %b want %b", c, b2.out_valid, ev); end
            if (ev) begin
                checks++; if (b2.out_data !== ed) begin errors++; $display("FAIL stream_out_data c=%0d: got %h want %h", c, b2.out_data, ed); end
            end
            next();
        end
        b2.in_valid = 1'b0;
        b2.out_ready = 1'b0;
    endtask

    task automatic test_backpressure();
        int got;
        b3.out_ready = 1'b0;
        for (int k = 0; k <= CAP3; k++) begin
            b3.in_valid = 1'b1;
            b3.in_data  = 32'hA1 + 32'(k);
            @(negedge clk);
            checks++; if (b3.in_ready !== (k < CAP3)) begin errors++; $display("FAIL bp_in_ready k=%0d: got %b want %b", k, b3.in_ready, (k < CAP3)); end
            next();
        end
        b3.in_valid = 1'b0;
        next();
        checks++; if (occ3 !== 3'(CAP3)) begin errors++; $display("FAIL bp_occ: got %0d want %0d", occ3, CAP3); end
        b3.out_ready = 1'b1;
        got = 0;
        for (int t = 0; t < 20; t++) begin
            @(negedge clk);
            if (b3.out_valid) begin
                checks++;
                if (got >= CAP3) begin errors++; $display("FAIL bp_extra_word: got %h want none", b3.out_data); end
                else if (b3.out_data !== 32'hA1 + 32'(got)) begin errors++; $display("FAIL bp_order %0d: got %h want %h", got, b3.out_data, 32'hA1 + 32'(got)); end
                got++;
            end
            next();
        end
        checks++; if (got != CAP3) begin errors++; $display("FAIL bp_count: got %0d want %0d", got, CAP3); end
        b3.out_ready = 1'b0;
    endtask

    task automatic test_flush();
        int got;
        b3.out_ready = 1'b0;
        b3.in_valid = 1'b1; b3.in_data = 32'h31; next();
        b3.in_data = 32'h32; next();
        b3.in_data = 32'h33; flush3 = 1'b1;
        @(negedge clk);
        checks++; if (occ3 !== 3'd2) begin errors++; $display("FAIL flush_pre_occ: got %0d want 2", occ3); end
`ifndef IR_PIPE_SKID_EN
        checks++; if (b3.in_ready !== 1'b0) begin errors++; $display("FAIL flush_in_ready: got %b want 0", b3.in_ready); end
`endif
        next();
        flush3 = 1'b0;
        checks++; if (occ3 !== 3'd0) begin errors++; $display("FAIL flush_occ: got %0d want 0", occ3); end
        checks++; if (b3.out_valid !== 1'b0 || b3.out_data !== NOP) begin errors++; $display("FAIL flush_out: got %b/%h want 0/%h", b3.out_valid, b3.out_data, NOP); end
        @(negedge clk);
        checks++; if (b3.in_ready !== 1'b1) begin errors++; $display("FAIL flush_reaccept: got %b want 1", b3.in_ready); end
        next();
        b3.in_valid = 1'b0;
        b3.out_ready = 1'b1;
        got = 0;
        for (int t = 0; t < 10; t++) begin
            @(negedge clk);
            if (b3.out_valid) begin
                checks++; if (b3.out_data !== 32'h33) begin errors++; $display("FAIL flush_word: got %h want 00000033", b3.out_data); end
                got++;
            end
            next();
        end
        checks++; if (got != 1) begin errors++; $display("FAIL flush_count: got %0d want 1", got); end
        b3.out_ready = 1'b0;
    endtask

    task automatic test_gap();
        b3.out_ready = 1'b0;
        b3.in_valid = 1'b1; b3.in_data = 32'h51; next();
        b3.in_valid = 1'b0; next();
        b3.in_valid = 1'b1; b3.in_data = 32'h52; next();
        b3.in_valid = 1'b0;
        repeat (4) next();
        checks++; if (occ3 !== 3'd2) begin errors++; $display("FAIL gap_occ: got %0d want 2", occ3); end
        b3.out_ready = 1'b1;
        @(negedge clk);
        checks++; if (b3.out_valid !== 1'b1 || b3.out_data !== 32'h51) begin errors++; $display("FAIL gap_first: got %b/%h want 1/00000051", b3.out_valid, b3.out_data); end
        next();
        @(negedge clk);
        checks++; if (b3.out_valid !== 1'b1 || b3.out_data !== 32'h52) begin errors++; $display("FAIL gap_second: got %b/%h want 1/00000052", b3.out_valid, b3.out_data); end
        next();
        @(negedge clk);
        checks++; if (b3.out_valid !== 1'b0) begin errors++; $display("FAIL gap_empty: got %b want 0", b3.out_valid); end
        next();
        b3.out_ready = 1'b0;
    endtask

    task automatic test_random();
        instr_t q[$];
        instr_t exp_w;
        logic   exp_rdy;
        for (int n = 0; n < 1000; n++) begin
            b3.in_valid  = ($urandom_range(0, 3) != 0);
            b3.in_data   = $urandom;
            b3.out_ready = $urandom_range(0, 1);
            @(negedge clk);
`ifdef IR_PIPE_SKID_EN
            exp_rdy = (q.size() < 4);
`else
            exp_rdy = (q.size() < 3) || b3.out_ready;
`endif
            checks++; if (b3.in_ready !== exp_rdy) begin errors++; $display("FAIL rnd_in_ready n=%0d: got %b want %b", n, b3.in_ready, exp_rdy); end
            checks++; if (occ3 !== 3'(q.size())) begin errors++; $display("FAIL rnd_occ n=%0d: got %0d want %0d", n, occ3, q.size()); end
            if (b3.out_valid && b3.out_ready) begin
                checks++;
                if (q.size() == 0) begin errors++; $display("FAIL rnd_spurious n=%0d: got %h want no word", n, b3.out_data); end
                else begin
                    exp_w = q.pop_front();
                    if (b3.out_data !== exp_w) begin errors++; $display("FAIL rnd_data n=%0d: got %h want %h", n, b3.out_data, exp_w); end
                end
            end
            if (b3.in_valid && b3.in_ready) q.push_back(b3.in_data);
            next();
        end
        b3.in_valid = 1'b0;
        b3.out_ready = 1'b1;
        for (int t = 0; t < 20; t++) begin
            @(negedge clk);
            if (b3.out_valid) begin
                checks++;
                if (q.size() == 0) begin errors++; $display("FAIL drain_spurious: got %h want no word", b3.out_data); end
                else begin
                    exp_w = q.pop_front();
                    if (b3.out_data !== exp_w) begin errors++; $display("FAIL drain_data: got %h want %h", b3.out_data, exp_w); end
                end
            end
            next();
        end
        checks++; if (q.size() != 0) begin errors++; $display("FAIL drain_left: got %0d words missing want 0", q.size()); end
        checks++; if (occ3 !== 3'd0) begin errors++; $display("FAIL drain_occ: got %0d want 0", occ3); end
        b3.out_ready = 1'b0;
    endtask

    initial begin
        b2.in_valid = 1'b0; b2.in_data = '0; b2.out_ready = 1'b0;
        b3.in_valid = 1'b0; b3.in_data = '0; b3.out_ready = 1'b0;
        test_reset();
        test_stream();
        test_backpressure();
        test_flush();
        test_gap();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
